// File: rtl/micro_sequencer.sv
// Microprogram sequencer: computes the next control-store address (uPC) from the
// current microword's next-address fields, ALU flags and the IR opcode.
// Optional microcycle watchdog is enabled with `define MICRO_SEQ_WATCHDOG_EN.
module micro_sequencer #(
  parameter int ADDR_W      = 10,
  parameter int FETCH_ADDR  = 0,
  parameter int MAX_UCYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        next_mode,
  input  logic [2:0]        cond_sel,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic [7:0]        opcode,
  input  logic              z_flag,
  input  logic              n_flag,
  input  logic              stall,
  output logic [ADDR_W-1:0] upc,
  output logic              wide_active,
  output logic              instr_done,
  output logic              illegal_op,
  output logic              seq_error,
  output logic [15:0]       retired_cnt
);

  typedef enum logic [2:0] {
    MODE_SEQ   = 3'b000,
    MODE_COND  = 3'b001,
    MODE_JUMP  = 3'b010,
    MODE_FETCH = 3'b110,
    MODE_MAP   = 3'b111
  } mode_t;

  localparam logic [ADDR_W-1:0] FETCH_UPC = ADDR_W'(FETCH_ADDR);
  localparam logic [2:0]        COND_WIDE = 3'b111;

  // The watchdog counter is 7 bits wide, so the limit must fit in it.
  if (MAX_UCYCLES < 1 || MAX_UCYCLES > 127) begin : g_bad_limit
    $error("MAX_UCYCLES must be in 1..127");
  end

  // Dispatch ROM: returns {hit, entry}; wide entries exist only for a few opcodes.
  function automatic logic [ADDR_W:0] map_entry(input logic [7:0] op, input logic wide);
    logic [ADDR_W-1:0] entry;
    logic              hit;
    hit   = 1'b1;
    entry = '0;
    case (op)
      8'h60: entry = ADDR_W'(4);
      8'h64: entry = ADDR_W'(13);
      8'h7E: entry = ADDR_W'(22);
      8'hB0: entry = ADDR_W'(31);
      8'hA7: entry = ADDR_W'(40);
      8'h99: entry = ADDR_W'(44);
      8'h9B: entry = ADDR_W'(51);
      8'h9F: entry = ADDR_W'(58);
      8'h00: entry = ADDR_W'(68);
      8'h57: entry = ADDR_W'(69);
      8'h59: entry = ADDR_W'(70);
      8'h15: entry = wide ? ADDR_W'(75)  : ADDR_W'(86);
      8'h36: entry = wide ? ADDR_W'(97)  : ADDR_W'(108);
      8'h10: entry = wide ? ADDR_W'(119) : ADDR_W'(130);
      8'h5F: entry = ADDR_W'(141);
      8'hC4: entry = ADDR_W'(152);
      8'h13: entry = ADDR_W'(153);
      8'h84: entry = wide ? ADDR_W'(240) : ADDR_W'(165);
      8'hB6: entry = ADDR_W'(181);
      8'hAC: entry = ADDR_W'(218);
      default: hit = 1'b0;
    endcase
    return {hit, entry};
  endfunction

  logic [ADDR_W-1:0] upc_nx;
  logic              wide_nx;
  logic              done_nx;
  logic              illegal_nx;
  logic              error_nx;
  logic [15:0]       retired_nx;
  logic [ADDR_W:0]   map_res;
  logic              taken;

`ifdef MICRO_SEQ_WATCHDOG_EN
  logic [6:0] wd_cnt;
  logic       wd_fire;
  assign wd_fire = (wd_cnt == 7'(MAX_UCYCLES));
`endif

  assign map_res = map_entry(opcode, wide_active);

  always_comb begin
    case (cond_sel)
      3'b000:  taken = z_flag;
      3'b001:  taken = n_flag;
      3'b010:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    upc_nx     = upc;
    wide_nx    = wide_active;
    retired_nx = retired_cnt;
    done_nx    = 1'b0;
    illegal_nx = 1'b0;
    error_nx   = 1'b0;
    if (!stall) begin
      case (mode_t'(next_mode))
        MODE_SEQ: begin
          upc_nx   = upc + 1'b1;
          error_nx = (upc == '1);
        end
        MODE_COND: begin
          if (taken) begin
            upc_nx = branch_addr;
          end else begin
            upc_nx   = upc + 1'b1;
            error_nx = (upc == '1);
          end
        end
        MODE_JUMP: upc_nx = branch_addr;
        MODE_FETCH: begin
          upc_nx = FETCH_UPC;
          if (cond_sel == COND_WIDE) begin
            wide_nx = 1'b1;
          end else begin
            done_nx    = 1'b1;
            retired_nx = retired_cnt + 16'd1;
          end
        end
        MODE_MAP: begin
          upc_nx     = map_res[ADDR_W] ? map_res[ADDR_W-1:0] : FETCH_UPC;
          illegal_nx = ~map_res[ADDR_W];
          wide_nx    = 1'b0;
        end
        default: begin
          upc_nx   = FETCH_UPC;
          error_nx = 1'b1;
        end
      endcase
`ifdef MICRO_SEQ_WATCHDOG_EN
      // A runaway microroutine is aborted back to fetch; it does not retire.
      if (wd_fire) begin
        upc_nx     = FETCH_UPC;
        wide_nx    = 1'b0;
        retired_nx = retired_cnt;
        done_nx    = 1'b0;
        illegal_nx = 1'b0;
        error_nx   = 1'b1;
      end
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      upc         <= FETCH_UPC;
      wide_active <= 1'b0;
      retired_cnt <= '0;
      instr_done  <= 1'b0;
      illegal_op  <= 1'b0;
      seq_error   <= 1'b0;
    end else begin
      upc         <= upc_nx;
      wide_active <= wide_nx;
      retired_cnt <= retired_nx;
      instr_done  <= done_nx;
      illegal_op  <= illegal_nx;
      seq_error   <= error_nx;
    end
  end

`ifdef MICRO_SEQ_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (!stall) begin
      if (wd_fire || next_mode == MODE_FETCH || next_mode == MODE_MAP) begin
        wd_cnt <= '0;
      end else begin
        wd_cnt <= wd_cnt + 7'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench for micro_sequencer: the driver queues hand-computed
// expectations, a monitor pops and compares them after every clock edge.
module tb_micro_sequencer;

  typedef struct {
    logic [9:0]  upc;
    logic        wide;
    logic        done;
    logic        ill;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  localparam logic [2:0] SEQ = 3'b000, COND = 3'b001, JMP = 3'b010,
                         FET = 3'b110, MAP = 3'b111;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  next_mode;
  logic [2:0]  cond_sel;
  logic [9:0]  branch_addr;
  logic [7:0]  opcode;
  logic        z_flag;
  logic        n_flag;
  logic        stall;
  logic [9:0]  upc;
  logic        wide_active;
  logic        instr_done;
  logic        illegal_op;
  logic        seq_error;
  logic [15:0] retired_cnt;

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  micro_sequencer dut (
    .clk(clk), .reset(reset), .next_mode(next_mode), .cond_sel(cond_sel),
    .branch_addr(branch_addr), .opcode(opcode), .z_flag(z_flag), .n_flag(n_flag),
    .stall(stall), .upc(upc), .wide_active(wide_active), .instr_done(instr_done),
    .illegal_op(illegal_op), .seq_error(seq_error), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [9:0] u, input logic w, input logic d,
                              input logic i, input logic e, input logic [15:0] c);
    exp_t x;
    x.upc = u; x.wide = w; x.done = d; x.ill = i; x.err = e; x.cnt = c;
    return x;
  endfunction

  // Drive one microcycle and queue the state expected after the next edge.
  task automatic step(input logic [2:0] m, input logic [2:0] cs, input logic [9:0] ba,
                      input logic [7:0] op, input logic z, input logic n,
                      input logic st, input logic rst, input exp_t e);
    next_mode = m; cond_sel = cs; branch_addr = ba; opcode = op;
    z_flag = z; n_flag = n; stall = st; reset = rst;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("upc",         16'(upc),         16'(e.upc));
        check("wide_active", 16'(wide_active), 16'(e.wide));
        check("instr_done",  16'(instr_done),  16'(e.done));
        check("illegal_op",  16'(illegal_op),  16'(e.ill));
        check("seq_error",   16'(seq_error),   16'(e.err));
        check("retired_cnt", retired_cnt,      e.cnt);
      end
    end
  end

  initial begin : driver
    // Reset, then sequential steps, dispatch and return to fetch.
    step(SEQ, 0, 0, 8'h00, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0));
    step(SEQ, 0, 0, 8'h00, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0));
    step(SEQ, 0, 0, 8'h00, 0, 0, 0, 0, mk(2, 0, 0, 0, 0, 0));
    step(SEQ, 0, 0, 8'h00, 0, 0, 0, 0, mk(3, 0, 0, 0, 0, 0));
    step(MAP, 0, 0, 8'h60, 0, 0, 0, 0, mk(4, 0, 0, 0, 0, 0));
    step(FET, 0, 0, 8'h00, 0, 0, 0, 0, mk(0, 0, 1, 0, 0, 1));

    // Conditional branches on Z, N, always and never.
    step(JMP,  0,  46, 8'h00, 0, 0, 0, 0, mk(46,  0, 0, 0, 0, 1));
    step(COND, 0,  47, 8'h00, 1, 0, 0, 0, mk(47,  0, 0, 0, 0, 1));
    step(JMP,  0,  46, 8'h00, 0, 0, 0, 0, mk(46,  0, 0, 0, 0, 1));
    step(COND, 0, 500, 8'h00, 0, 1, 0, 0, mk(47,  0, 0, 0, 0, 1));
    step(JMP,  0,  53, 8'h00, 0, 0, 0, 0, mk(53,  0, 0, 0, 0, 1));
    step(COND, 1,  54, 8'h00, 1, 0, 0, 0, mk(54,  0, 0, 0, 0, 1));
    step(COND, 1, 200, 8'h00, 0, 1, 0, 0, mk(200, 0, 0, 0, 0, 1));
    step(COND, 2, 300, 8'h00, 0, 0, 0, 0, mk(300, 0, 0, 0, 0, 1));
    step(COND, 3,   5, 8'h00, 1, 1, 0, 0, mk(301, 0, 0, 0, 0, 1));

    // WIDE prefix: no retirement, double WIDE stays set, wide map entries.
    step(FET, 7, 0, 8'h00, 0, 0, 0, 0, mk(0,   1, 0, 0, 0, 1));
    step(FET, 7, 0, 8'h00, 0, 0, 0, 0, mk(0,   1, 0, 0, 0, 1));
    step(MAP, 0, 0, 8'h15, 0, 0, 0, 0, mk(75,  0, 0, 0, 0, 1));
    step(MAP, 0, 0, 8'h84, 0, 0, 0, 0, mk(165, 0, 0, 0, 0, 1));
    step(FET, 0, 0, 8'h00, 0, 0, 0, 0, mk(0,   0, 1, 0, 0, 2));
    step(FET, 7, 0, 8'h00, 0, 0, 0, 0, mk(0,   1, 0, 0, 0, 2));
    step(MAP, 0, 0, 8'h84, 0, 0, 0, 0, mk(240, 0, 0, 0, 0, 2));
    step(FET, 7, 0, 8'h00, 0, 0, 0, 0, mk(0,   1, 0, 0, 0, 2));
    step(MAP, 0, 0, 8'h60, 0, 0, 0, 0, mk(4,   0, 0, 0, 0, 2));

    // Unmapped opcode clears WIDE and pulses illegal_op for one cycle.
    step(FET, 7, 0, 8'h00, 0, 0, 0, 0, mk(0, 1, 0, 0, 0, 2));
    step(MAP, 0, 0, 8'hFF, 0, 0, 0, 0, mk(0, 0, 0, 1, 0, 2));
    step(SEQ, 0, 0, 8'h00, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 2));

    // Reserved modes.
    step(3'b100, 0, 0, 8'h00, 0, 0, 0, 0, mk(0, 0, 0, 0, 1, 2));
    step(3'b011, 0, 0, 8'h00, 0, 0, 0, 0, mk(0, 0, 0, 0, 1, 2));
    step(SEQ,    0, 0, 8'h00, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 2));
    step(3'b101, 0, 0, 8'h00, 0, 0, 0, 0, mk(0, 0, 0, 0, 1, 2));

    // uPC overflow from the top address.
    step(JMP,  0, 1023, 8'h00, 0, 0, 0, 0, mk(1023, 0, 0, 0, 0, 2));
    step(SEQ,  0,    0, 8'h00, 0, 0, 0, 0, mk(0,    0, 0, 0, 1, 2));
    step(JMP,  0, 1023, 8'h00, 0, 0, 0, 0, mk(1023, 0, 0, 0, 0, 2));
    step(COND, 0,    9, 8'h00, 0, 0, 0, 0, mk(0,    0, 0, 0, 1, 2));
    step(JMP,  0, 1023, 8'h00, 0, 0, 0, 0, mk(1023, 0, 0, 0, 0, 2));
    step(COND, 2,    7, 8'h00, 0, 0, 0, 0, mk(7,    0, 0, 0, 0, 2));

    // Stall holds state and suppresses pulses, even for FETCH and reserved modes.
    step(JMP, 0, 10, 8'h00, 0, 0, 0, 0, mk(10, 0, 0, 0, 0, 2));
    for (int i = 0; i < 5; i++)
      step(SEQ, 0, 0, 8'h00, 0, 0, 1, 0, mk(10, 0, 0, 0, 0, 2));
    step(FET,    0, 0, 8'h00, 0, 0, 1, 0, mk(10, 0, 0, 0, 0, 2));
    step(3'b100, 0, 0, 8'h00, 0, 0, 1, 0, mk(10, 0, 0, 0, 0, 2));
    step(MAP,    0, 0, 8'hFF, 0, 0, 1, 0, mk(10, 0, 0, 0, 0, 2));
    step(SEQ,    0, 0, 8'h00, 0, 0, 0, 0, mk(11, 0, 0, 0, 0, 2));

    // Reset dominates stall, then counting restarts from zero.
    step(FET, 7, 0, 8'h00, 0, 0, 0, 0, mk(0,  1, 0, 0, 0, 2));
    step(JMP, 0, 99, 8'h00, 0, 0, 1, 1, mk(0, 0, 0, 0, 0, 0));
    step(JMP, 0, 99, 8'h00, 0, 0, 0, 0, mk(99, 0, 0, 0, 0, 0));
    step(FET, 0, 0, 8'h00, 0, 0, 0, 0, mk(0,  0, 1, 0, 0, 1));

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(posedge clk);
    #2;
    check("scoreboard_drained", 16'(sb_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Microprogram sequencer for the stack-machine control store. It drives the 10-bit control-store address (uPC) each cycle.
- Inputs are the next-address fields of the current 26-bit microword, ALU flags Z/N, and the IR opcode.
- Handles sequential step, conditional branch, dispatch (map) from opcode, return-to-fetch and the WIDE prefix.
- Sits between IR/ALU flags and the control store; the control store is combinational, so the microword at uPC is valid in the same cycle.

Parameters:
- ADDR_W, 10, control-store address width
- FETCH_ADDR, 0, fetch microroutine entry
- MAX_UCYCLES, 64, watchdog limit in microcycles per instruction (optional feature only)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- next_mode  in  3  microword bits [15:13]
- cond_sel  in  3  microword bits [12:10]
- branch_addr  in  10  microword bits [9:0]
- opcode  in  8  IR contents
- z_flag  in  1  ALU zero flag
- n_flag  in  1  ALU negative flag
- stall  in  1  memory not ready; hold sequencer
- upc  out  10  control-store address
- wide_active  out  1  WIDE prefix pending
- instr_done  out  1  one-cycle pulse on return to fetch
- illegal_op  out  1  one-cycle pulse, unmapped opcode
- seq_error  out  1  one-cycle pulse, reserved mode or uPC overflow
- retired_cnt  out  16  retired instruction count

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: upc=0, wide_active=0, instr_done=0, illegal_op=0, seq_error=0, retired_cnt=0. Reset dominates stall.
- All updates occur on the rising clk edge. Pulse outputs are registered and asserted in the cycle after the decision.
- stall=1: upc, wide_active and retired_cnt hold; pulse outputs are 0.
- next_mode decode, evaluated when stall=0:
  - 000 SEQ: upc <= upc+1.
  - 001 COND: taken = (cond_sel==000 ? z_flag : cond_sel==001 ? n_flag : cond_sel==010 ? 1 : 0). upc <= taken ? branch_addr : upc+1.
  - 010 JUMP: upc <= branch_addr.
  - 110 FETCH: upc <= FETCH_ADDR; instr_done pulses; retired_cnt increments, wrapping 0xFFFF->0.
    - If cond_sel==111 (WIDE prefix): wide_active <= 1, and retired_cnt and instr_done are unaffected.
  - 111 MAP: upc <= map(opcode, wide_active); wide_active <= 0.
  - 011/100/101 reserved: upc <= FETCH_ADDR, seq_error pulses.
- SEQ or COND-not-taken at upc=1023: upc wraps to 0 and seq_error pulses.
- Map table, opcode -> entry (entry when wide_active=1 in brackets):
  - 0x60->4, 0x64->13, 0x7E->22, 0xB0->31
  - 0xA7->40, 0x99->44, 0x9B->51, 0x9F->58
  - 0x00->68, 0x57->69, 0x59->70
  - 0x15->86 [75], 0x36->108 [97], 0x10->130 [119]
  - 0x5F->141, 0xC4->152, 0x13->153
  - 0x84->165 [240], 0xB6->181, 0xAC->218
- Opcodes without a bracketed entry ignore wide_active, but MAP still clears it.
- Unlisted opcode: upc <= FETCH_ADDR, illegal_op pulses, wide_active cleared.
- A second WIDE while wide_active=1 keeps it at 1.
- Flags and opcode are sampled combinationally in the decision cycle; the sequencer does not latch them.

Optional Feature:
- Macro: MICRO_SEQ_WATCHDOG_EN.
- Enabled:
  - A 7-bit counter resets to 0 on reset and on every FETCH/MAP transition, and increments on each non-stalled cycle otherwise.
  - When the counter reaches MAX_UCYCLES: upc <= FETCH_ADDR, wide_active <= 0, seq_error pulses, counter clears.
  - Stalled cycles are not counted.
- Disabled: no counter exists, and seq_error is driven only by the reserved-mode and overflow cases.

Test Plan:
- Reset then drive SEQ words for 3 cycles -> upc 0,1,2,3. Then MAP with opcode 0x60 -> upc=4. Then FETCH -> upc=0, instr_done=1, retired_cnt=1.
- At upc=46: COND cond_sel=000 branch_addr=47 with z_flag=1 -> upc=47. Repeat with z_flag=0 -> upc=47 via SEQ. At upc=53: cond_sel=001 branch_addr=54 with n_flag=0 -> upc=54 (sequential).
- FETCH with cond_sel=111 -> wide_active=1, retired_cnt unchanged. MAP with opcode 0x15 -> upc=75, wide_active=0. Repeat with opcode 0x84 and no WIDE -> upc=165.
- MAP with opcode 0xFF -> upc=0, illegal_op pulses one cycle. Separately, next_mode=100 -> upc=0, seq_error=1.
- stall=1 for 5 cycles during SEQ at upc=10 -> upc stays 10. Assert reset while stall=1 -> upc=0 next edge.
- With MICRO_SEQ_WATCHDOG_EN and MAX_UCYCLES=64: after MAP, drive JUMP to the same address for 64 cycles -> upc forced to 0, seq_error pulses once.
